// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks an 8:1 mux over the enabled channels and hands the sampled snapshot word downstream on a valid/ready handshake
module mux_scan_ctrl #(
  parameter int DWELL_CYCLES = 2,
  parameter bit CONT_MODE    = 1'b0
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic [7:0] mask_in,
  input  logic       mux_y_in,
  input  logic       ready_in,
  output logic [2:0] sel_out,
  output logic       busy_out,
  output logic [7:0] word_out,
  output logic       valid_out,
  output logic       ovr_out
);
  localparam int W = $clog2(DWELL_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
  state_t state, state_n;
  logic [W-1:0] dwell, dwell_n;
  logic [7:0] shadow, shadow_n, mask, mask_n, word_n, merged, above;
  logic [2:0] sel_n;
  logic accept, last, ovr_n;
  function automatic logic [2:0] lowest(input logic [7:0] m);
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--) if (m[i]) lowest = i[2:0];
  endfunction
  assign busy_out  = state == SCAN;
  assign valid_out = state == HOLD;
  // next state: start acceptance, dwell/sample stepping and the HOLD handshake
  always_comb begin
    state_n  = state;
    sel_n    = sel_out;
    dwell_n  = dwell;
    shadow_n = shadow;
    mask_n   = mask;
    word_n   = word_out;
    merged   = shadow;
    merged[sel_out] = mux_y_in;
    above    = mask & (8'hFE << sel_out);
    last     = dwell == W'(DWELL_CYCLES - 1);
    accept   = start_in && (state == IDLE || (state == HOLD && ready_in));
    ovr_n    = start_in && !accept;
    if (accept) begin
      mask_n   = mask_in;
      shadow_n = 8'h00;
      dwell_n  = '0;
      state_n  = mask_in != 8'h00 ? SCAN : HOLD;
      sel_n    = lowest(mask_in);
      word_n   = mask_in != 8'h00 ? word_out : 8'h00;
    end else if (state == SCAN) begin
      dwell_n = last ? '0 : dwell + 1'b1;
      if (last) begin
        shadow_n = merged;
        sel_n    = above != 8'h00 ? lowest(above) : 3'd0;
        state_n  = above != 8'h00 ? SCAN : HOLD;
        word_n   = above != 8'h00 ? word_out : merged;
      end
    end else if (state == HOLD && ready_in) begin
      if (!CONT_MODE) begin
        state_n = IDLE;
        sel_n   = 3'd0;
      end else if (mask != 8'h00) begin
        state_n  = SCAN;
        sel_n    = lowest(mask);
        shadow_n = 8'h00;
        dwell_n  = '0;
      end
    end
  end
  // state and datapath registers; reset aborts any scan immediately
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      sel_out  <= 3'd0;
      dwell    <= '0;
      shadow   <= 8'h00;
      mask     <= 8'h00;
      word_out <= 8'h00;
      ovr_out  <= 1'b0;
    end else begin
      state    <= state_n;
      sel_out  <= sel_n;
      dwell    <= dwell_n;
      shadow   <= shadow_n;
      mask     <= mask_n;
      word_out <= word_n;
      ovr_out  <= ovr_n;
    end
  end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed vectors and corner sequences for single-shot and continuous scanning
module tb_mux_scan_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic start0 = 1'b0, ready0 = 1'b1, start1 = 1'b0, ready1 = 1'b1;
  logic [7:0] mask0 = 8'h00, mask1 = 8'h00, d0 = 8'h00, d1 = 8'h00;
  logic [2:0] sel0, sel1;
  logic busy0, busy1, valid0, valid1, ovr0, ovr1, y0, y1;
  logic [7:0] word0, word1;
  int checks = 0, failures = 0;
  assign y0 = d0[sel0];
  assign y1 = d1[sel1];
  always #5 clk = ~clk;
  mux_scan_ctrl #(.DWELL_CYCLES(2), .CONT_MODE(1'b0)) u0 (
    .clk_in(clk), .rst_in(rst), .start_in(start0), .mask_in(mask0), .mux_y_in(y0),
    .ready_in(ready0), .sel_out(sel0), .busy_out(busy0), .word_out(word0),
    .valid_out(valid0), .ovr_out(ovr0));
  mux_scan_ctrl #(.DWELL_CYCLES(2), .CONT_MODE(1'b1)) u1 (
    .clk_in(clk), .rst_in(rst), .start_in(start1), .mask_in(mask1), .mux_y_in(y1),
    .ready_in(ready1), .sel_out(sel1), .busy_out(busy1), .word_out(word1),
    .valid_out(valid1), .ovr_out(ovr1));
  typedef struct {logic [7:0] mask; logic [7:0] d; logic [7:0] word; int lat;} vec_t;
  vec_t tbl[7];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic int nth_bit(input logic [7:0] m, input int n);
    int c = 0;
    for (int b = 0; b < 8; b++) if (m[b]) begin
      if (c == n) return b;
      c++;
    end
    return -1;
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int k, bad, oc;
    logic [7:0] cd[3];
    tbl[0] = '{8'hFF, 8'hA5, 8'hA5, 16};
    tbl[1] = '{8'h81, 8'hFF, 8'h81, 4};
    tbl[2] = '{8'h0F, 8'h3C, 8'h0C, 8};
    tbl[3] = '{8'h00, 8'hFF, 8'h00, 0};
    tbl[4] = '{8'h5A, 8'hF0, 8'h50, 8};
    tbl[5] = '{8'h80, 8'h80, 8'h80, 2};
    tbl[6] = '{8'h01, 8'h00, 8'h00, 2};
    cd[0] = 8'hA5; cd[1] = 8'h3C; cd[2] = 8'h5A;
    #3;
    chk("reset_outputs", {sel0, busy0, valid0, word0, ovr0}, 0);
    tick; tick;
    rst = 1'b0;
    tick;
    chk("idle_after_reset", {sel0, busy0, valid0}, 0);
    for (int i = 0; i < 7; i++) begin
      mask0 = tbl[i].mask; d0 = tbl[i].d; ready0 = 1'b1; start0 = 1'b1;
      tick;
      start0 = 1'b0;
      k = 0; bad = 0;
      while (!valid0 && k < 100) begin
        if (!busy0 || int'(sel0) != nth_bit(tbl[i].mask, k / 2)) bad++;
        tick; k++;
      end
      chk($sformatf("latency_%0d", i), k, tbl[i].lat);
      chk($sformatf("word_%0d", i), word0, tbl[i].word);
      chk($sformatf("sel_trace_%0d", i), bad, 0);
      tick;
      chk($sformatf("back_to_idle_%0d", i), {valid0, busy0, sel0}, 0);
    end
    ready0 = 1'b0; mask0 = 8'hFF; d0 = 8'hA5; start0 = 1'b1;
    tick;
    start0 = 1'b0;
    k = 0;
    while (!valid0 && k < 100) begin tick; k++; end
    chk("bp_latency", k, 16);
    chk("bp_word", word0, 8'hA5);
    bad = 0; oc = 0;
    for (int j = 0; j < 5; j++) begin
      start0 = (j == 1);
      mask0 = (j == 1) ? 8'h01 : 8'hFF;
      tick;
      start0 = 1'b0;
      oc += int'(ovr0);
      if (!valid0 || busy0 || word0 != 8'hA5) bad++;
    end
    chk("bp_hold_stable", bad, 0);
    chk("ovr_pulse_count", oc, 1);
    d0 = 8'h3C; mask0 = 8'h0F; ready0 = 1'b1; start0 = 1'b1;
    tick;
    start0 = 1'b0;
    chk("restart_same_edge", {valid0, busy0, sel0}, {1'b0, 1'b1, 3'd0});
    k = 0;
    while (!valid0 && k < 100) begin tick; k++; end
    chk("second_latency", k, 8);
    chk("second_word", word0, 8'h0C);
    tick;
    mask0 = 8'hFF; d0 = 8'hA5; start0 = 1'b1;
    tick;
    start0 = 1'b0;
    k = 0;
    while (sel0 != 3'd3 && k < 100) begin tick; k++; end
    chk("abort_reach_sel3", sel0, 3);
    #3 rst = 1'b1;
    #1 chk("abort_outputs", {sel0, busy0, valid0, word0, ovr0}, 0);
    tick;
    rst = 1'b0;
    bad = 0;
    for (int j = 0; j < 20; j++) begin
      tick;
      if (valid0 || busy0) bad++;
    end
    chk("abort_no_valid", bad, 0);
    mask1 = 8'hFF; d1 = cd[0]; ready1 = 1'b1; start1 = 1'b1;
    tick;
    start1 = 1'b0;
    for (int w = 0; w < 3; w++) begin
      k = 0;
      while (!valid1 && k < 100) begin tick; k++; end
      chk($sformatf("cont_latency_%0d", w), k, 16);
      chk($sformatf("cont_word_%0d", w), word1, cd[w]);
      if (w < 2) d1 = cd[w + 1];
      tick;
      chk($sformatf("cont_rescan_%0d", w), {busy1, valid1, sel1}, {1'b1, 1'b0, 3'd0});
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    mask1 = 8'h00; ready1 = 1'b0; start1 = 1'b1;
    tick;
    start1 = 1'b0;
    chk("cont_empty_hold", {valid1, busy1, word1}, {1'b1, 1'b0, 8'h00});
    ready1 = 1'b1;
    bad = 0;
    for (int j = 0; j < 3; j++) begin
      tick;
      if (!valid1 || busy1 || word1 != 8'h00) bad++;
    end
    chk("cont_empty_represent", bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
